// File: rtl/riscv_pkg.sv
// Shared RV32E decode constants: opcodes, immediate formats and the ID-stage record.
package riscv_pkg;

   localparam int XLEN      = 32;
   localparam int NREG      = 16;
   localparam int REG_IDX_W = $clog2(NREG);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // IMM_NONE covers OP and unknown opcodes, which carry no immediate.
   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_fmt_e;

   typedef struct packed {
      logic [XLEN-1:0]      pc;
      logic [6:0]           opcode;
      logic [2:0]           funct3;
      logic [6:0]           funct7;
      logic [REG_IDX_W-1:0] rd;
      logic                 we;
      logic [XLEN-1:0]      imm;
      logic                 illegal;
   } id_bundle_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch, register-file read, execute and writeback signals around the decode stage.
// Handshake: a transfer happens on a cycle where valid && ready; valid never waits on ready.
interface decode_stage_if;
   import riscv_pkg::*;

   logic                 if_valid;
   logic                 if_ready;
   logic [XLEN-1:0]      if_instr;
   logic [XLEN-1:0]      if_pc;
   logic                 rf_re;
   logic [REG_IDX_W-1:0] rf_rs1;
   logic [REG_IDX_W-1:0] rf_rs2;
   logic                 id_valid;
   logic                 id_ready;
   logic [XLEN-1:0]      id_pc;
   logic [6:0]           id_opcode;
   logic [2:0]           id_funct3;
   logic [6:0]           id_funct7;
   logic [REG_IDX_W-1:0] id_rd;
   logic                 id_we;
   logic [XLEN-1:0]      id_imm;
   logic                 id_illegal;
   logic                 wb_valid;
   logic [REG_IDX_W-1:0] wb_rd;
   logic                 flush;
   logic [NREG-1:0]      dbg_busy;

   modport slave (
      input  if_valid, if_instr, if_pc, id_ready, wb_valid, wb_rd, flush,
      output if_ready, rf_re, rf_rs1, rf_rs2, id_valid, id_pc, id_opcode, id_funct3,
             id_funct7, id_rd, id_we, id_imm, id_illegal, dbg_busy
   );

   modport master (
      output if_valid, if_instr, if_pc, id_ready, wb_valid, wb_rd, flush,
      input  if_ready, rf_re, rf_rs1, rf_rs2, id_valid, id_pc, id_opcode, id_funct3,
             id_funct7, id_rd, id_we, id_imm, id_illegal, dbg_busy
   );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate extraction; opcode bits are not needed here.
module imm_gen
   import riscv_pkg::*;
(
   input  logic [31:7]     instr_i,
   input  imm_fmt_e        fmt_i,
   output logic [XLEN-1:0] imm_o
);

   always_comb begin
      imm_o = '0;
      case (fmt_i)
         IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
         IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
         IMM_U: imm_o = {instr_i[31:12], 12'h000};
         IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
         default: imm_o = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// RV32E decode stage: field decode, RAW scoreboard with stall, and the ID pipeline register.
module decode_stage
   import riscv_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   decode_stage_if.slave bus
);

   logic [6:0]           opc;
   logic [REG_IDX_W-1:0] rs1, rs2, rd;
   logic                 legal, use_rs1, use_rs2, has_rd;
   logic                 reg_bad, illegal;
   imm_fmt_e             fmt;
   logic [XLEN-1:0]      imm;
   logic                 hit_rs1, hit_rs2, hazard;
   logic                 ready, accept, handshake;

   id_bundle_t           id_q, id_d;
   logic                 id_valid_q, id_valid_d;
   logic [NREG-1:0]      busy_q, busy_d;

   assign opc = bus.if_instr[6:0];
   assign rs1 = bus.if_instr[18:15];
   assign rs2 = bus.if_instr[23:20];
   assign rd  = bus.if_instr[10:7];

   always_comb begin
      legal   = 1'b1;
      use_rs1 = 1'b1;
      use_rs2 = 1'b0;
      has_rd  = 1'b1;
      fmt     = IMM_I;
      case (opc)
         OPC_LUI, OPC_AUIPC: begin use_rs1 = 1'b0; fmt = IMM_U; end
         OPC_JAL:            begin use_rs1 = 1'b0; fmt = IMM_J; end
         OPC_JALR, OPC_LOAD, OPC_OPIMM: fmt = IMM_I;
         OPC_BRANCH:         begin use_rs2 = 1'b1; has_rd = 1'b0; fmt = IMM_B; end
         OPC_STORE:          begin use_rs2 = 1'b1; has_rd = 1'b0; fmt = IMM_S; end
         OPC_OP:             begin use_rs2 = 1'b1; fmt = IMM_NONE; end
         default: begin
            legal   = 1'b0;
            use_rs1 = 1'b0;
            has_rd  = 1'b0;
            fmt     = IMM_NONE;
         end
      endcase
   end

   // Bit 4 of any used register field addresses beyond the RV32E file.
   assign reg_bad = (use_rs1 && bus.if_instr[19]) || (use_rs2 && bus.if_instr[24]) ||
                    (has_rd && bus.if_instr[11]);
   assign illegal = !legal || reg_bad;

   imm_gen u_imm_gen (
      .instr_i (bus.if_instr[31:7]),
      .fmt_i   (fmt),
      .imm_o   (imm)
   );

   // The held instruction counts as pending even while it is being handed off.
   assign hit_rs1 = (rs1 != '0) && (busy_q[rs1] || (id_valid_q && id_q.we && id_q.rd == rs1));
   assign hit_rs2 = (rs2 != '0) && (busy_q[rs2] || (id_valid_q && id_q.we && id_q.rd == rs2));
   assign hazard  = (use_rs1 && hit_rs1) || (use_rs2 && hit_rs2);

   assign ready     = !reset && !hazard && (!id_valid_q || bus.id_ready) && !bus.flush;
   assign accept    = bus.if_valid && ready;
   assign handshake = id_valid_q && bus.id_ready && !bus.flush;

   always_comb begin
      busy_d = busy_q;
      if (bus.wb_valid) busy_d[bus.wb_rd] = 1'b0;
      if (handshake && id_q.we) busy_d[id_q.rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      id_d       = id_q;
      id_valid_d = id_valid_q;
      if (bus.flush) begin
         id_valid_d = 1'b0;
      end else if (accept) begin
         id_valid_d     = 1'b1;
         id_d.pc        = bus.if_pc;
         id_d.opcode    = opc;
         id_d.funct3    = bus.if_instr[14:12];
         id_d.funct7    = bus.if_instr[31:25];
         id_d.rd        = rd;
         id_d.we        = has_rd && !illegal && (rd != '0);
         id_d.imm       = imm;
         id_d.illegal   = illegal;
      end else if (handshake) begin
         id_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         id_q       <= '0;
         id_valid_q <= 1'b0;
         busy_q     <= '0;
      end else begin
         id_q       <= id_d;
         id_valid_q <= id_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.if_ready   = ready;
   assign bus.rf_re      = accept;
   assign bus.rf_rs1     = rs1;
   assign bus.rf_rs2     = rs2;
   assign bus.id_valid   = id_valid_q;
   assign bus.id_pc      = id_q.pc;
   assign bus.id_opcode  = id_q.opcode;
   assign bus.id_funct3  = id_q.funct3;
   assign bus.id_funct7  = id_q.funct7;
   assign bus.id_rd      = id_q.rd;
   assign bus.id_we      = id_q.we;
   assign bus.id_imm     = id_q.imm;
   assign bus.id_illegal = id_q.illegal;
   assign bus.dbg_busy   = busy_q;

endmodule
